// File: rtl/seed_sweep_pkg.sv
// Shared state encoding and lane-interface constants for the seed sweep sequencer.
package seed_sweep_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_CLEAR,
      S_LDINH,
      S_GAP,
      S_START,
      S_RUN,
      S_REPORT,
      S_FIN
   } sweep_state_t;

   localparam logic LANE_CLR_ACTIVE = 1'b1;

endpackage

// File: rtl/lane_steady_tracker.sv
// Per-lane sticky steady-state flag plus the iteration at which the lane first went steady.
module lane_steady_tracker
   import seed_sweep_pkg::*;
#(
   parameter int LOG_ITER = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                run,
   input  logic                steady,
   input  logic [LOG_ITER-1:0] iter,
   output logic                flag,
   output logic [LOG_ITER-1:0] ss_iter
);

   // Only the first steady observation is kept; later drops are ignored.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         flag    <= 1'b0;
         ss_iter <= '0;
      end else if (run && steady && !flag) begin
         flag    <= 1'b1;
         ss_iter <= iter;
      end
   end

endmodule

// File: rtl/seed_sweep_ctrl.sv
// Sweeps a seed table through NUM_LANES lockstep datapath lanes and streams
// per-seed steady-state results over a valid/ready port.
module seed_sweep_ctrl
   import seed_sweep_pkg::*;
#(
   parameter int NUM_LANES  = 2,
   parameter int SEED_W     = 64,
   parameter int LOG_ITER   = 8,
   parameter int LOG_RULES  = 5,
   parameter int NUM_SEEDS  = 16,
   parameter int EARLY_EXIT = 1,
   localparam int SEED_AW   = $clog2(NUM_SEEDS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          go,
   input  logic                          abort,
   input  logic [LOG_RULES-1:0]          inhibitor_sel,
   input  logic [LOG_ITER-1:0]           max_iter,
   output logic                          seed_rd,
   output logic [SEED_AW-1:0]            seed_addr,
   input  logic [NUM_LANES*SEED_W-1:0]   seed_data,
   output logic                          lane_clr,
   output logic                          lane_ld_inhibitor,
   output logic [LOG_RULES-1:0]          lane_sel_inhibitor,
   output logic                          lane_start,
   output logic [NUM_LANES*SEED_W-1:0]   lane_seed,
   input  logic [LOG_ITER-1:0]           iteration_number,
   input  logic [NUM_LANES-1:0]          steady_state,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [SEED_AW-1:0]            res_seed_idx,
   output logic [NUM_LANES-1:0]          res_steady,
   output logic [NUM_LANES*LOG_ITER-1:0] res_ss_iter,
   output logic                          busy,
   output logic                          done,
   output logic                          aborted
);

   localparam logic [SEED_AW-1:0] LAST_IDX = SEED_AW'(NUM_SEEDS - 1);

   sweep_state_t                         state, state_nxt;
   logic [SEED_AW-1:0]                   idx;
   logic [LOG_ITER-1:0]                  max_q;
   logic [NUM_LANES*SEED_W-1:0]          seed_q;
   logic                                 aborted_q;
   logic [NUM_LANES-1:0]                 flag;
   logic [NUM_LANES-1:0][LOG_ITER-1:0]   ss_iter;
   logic                                 run_done, last, seed_hold;

   assign last      = (idx == LAST_IDX);
   assign run_done  = (iteration_number >= max_q) || ((EARLY_EXIT != 0) && (&steady_state));
   assign seed_hold = state inside {S_CLEAR, S_LDINH, S_GAP, S_START, S_RUN, S_REPORT};

   always_comb begin
      state_nxt         = state;
      seed_rd           = 1'b0;
      lane_clr          = ~LANE_CLR_ACTIVE;
      lane_ld_inhibitor = 1'b0;
      lane_start        = 1'b0;
      res_valid         = 1'b0;
      done              = 1'b0;
      case (state)
         S_IDLE:   if (go) state_nxt = S_FETCH;
         S_FETCH:  begin seed_rd = 1'b1; state_nxt = S_LOAD; end
         S_LOAD:   state_nxt = S_CLEAR;
         S_CLEAR:  begin lane_clr = LANE_CLR_ACTIVE; state_nxt = S_LDINH; end
         S_LDINH:  begin lane_ld_inhibitor = 1'b1; state_nxt = S_GAP; end
         S_GAP:    state_nxt = S_START;
         S_START:  begin lane_start = 1'b1; state_nxt = S_RUN; end
         S_RUN:    if (run_done) state_nxt = S_REPORT;
         S_REPORT: begin
            res_valid = 1'b1;
            if (res_ready) state_nxt = last ? S_FIN : S_FETCH;
         end
         S_FIN:    begin done = 1'b1; state_nxt = S_IDLE; end
         default:  state_nxt = S_IDLE;
      endcase
      if (abort) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= S_IDLE;
         idx                <= '0;
         max_q              <= '0;
         lane_sel_inhibitor <= '0;
         seed_q             <= '0;
         aborted_q          <= 1'b0;
      end else begin
         state     <= state_nxt;
         aborted_q <= abort;
         if (state == S_IDLE && go && !abort) begin
            idx                <= '0;
            max_q              <= max_iter;
            lane_sel_inhibitor <= ~inhibitor_sel;
         end
         if (state == S_LOAD) seed_q <= seed_data;
         if (state == S_REPORT && res_ready && !abort && !last) idx <= idx + 1'b1;
      end
   end

   // Outputs are forced to zero outside the phases where they carry meaning.
   assign seed_addr    = seed_rd ? idx : '0;
   assign lane_seed    = seed_hold ? seed_q : '0;
   assign res_seed_idx = res_valid ? idx : '0;
   assign res_steady   = res_valid ? flag : '0;
   assign res_ss_iter  = res_valid ? ss_iter : '0;
   assign busy         = (state != S_IDLE);
   assign aborted      = aborted_q;

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      lane_steady_tracker #(.LOG_ITER(LOG_ITER)) u_trk (
         .clk     (clk),
         .rst     (rst),
         .clr     (state == S_CLEAR),
         .run     (state == S_RUN),
         .steady  (steady_state[k]),
         .iter    (iteration_number),
         .flag    (flag[k]),
         .ss_iter (ss_iter[k])
      );
   end

endmodule
